// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register word offsets, FSM states and the
// CP0 register numbers the exception handler pairs with them.
package int_ctrl_pkg;

    // Word offsets, selected by bus_addr[4:2]
    localparam logic [2:0] RegPend   = 3'd0;
    localparam logic [2:0] RegMask   = 3'd1;
    localparam logic [2:0] RegEdge   = 3'd2;
    localparam logic [2:0] RegClaim  = 3'd3;
    localparam logic [2:0] RegStatus = 3'd4;

    localparam logic [4:0] Cp0Status = 5'd12;
    localparam logic [4:0] Cp0Cause  = 5'd13;
    localparam logic [4:0] Cp0Epc    = 5'd14;

    typedef enum logic [0:0] {
        StIdle,
        StService
    } int_state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder over NSRC request lines.
module int_prio_enc #(
    parameter int unsigned NSRC = 8
) (
    input  logic [NSRC-1:0] req,
    output logic            valid,
    output logic [4:0]      idx
);

    // Scan downwards so the lowest set index is the last assignment.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = 5'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Programmable interrupt controller driving one CP0 HWInt line with claim/complete handshake.
// Define INT_CTRL_SYNC_EN to pass src through a 2-flop synchronizer before sampling.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned NSRC = 8,
    parameter int unsigned LINE = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NSRC-1:0] src,
    input  logic [4:0]      bus_addr,
    input  logic            bus_we,
    input  logic            bus_re,
    input  logic [31:0]     bus_wdata,
    output logic [31:0]     bus_rdata,
    output logic [5:0]      hw_int,
    output logic [4:0]      irq_id
);

    logic [NSRC-1:0] src_s, hist_q, pend_q, pend_d, mask_q, edge_q, pend_en, set, clr;
    int_state_e      state_q;
    logic [4:0]      isr_id_q, win_idx, win_id;
    logic            win_valid, hw_q, claim, complete, w1c;
    logic [2:0]      reg_sel;
    logic            unused_bits;

    assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:NSRC]};

`ifdef INT_CTRL_SYNC_EN
    logic [NSRC-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= src;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = src;
`endif

    assign pend_en = pend_q & mask_q;

    int_prio_enc #(
        .NSRC(NSRC)
    ) u_prio_enc (
        .req  (pend_en),
        .valid(win_valid),
        .idx  (win_idx)
    );

    assign win_id   = win_idx + 5'd1;
    assign reg_sel  = bus_addr[4:2];
    assign claim    = bus_re && (reg_sel == RegClaim) && (state_q == StIdle) && win_valid;
    assign complete = bus_we && (reg_sel == RegClaim) && (state_q == StService) &&
                      (bus_wdata[4:0] == isr_id_q);
    assign w1c      = bus_we && (reg_sel == RegPend);
    assign set      = src_s & ~hist_q;

    // Edge bits: set beats clear; level bits simply follow the sampled line.
    always_comb begin
        for (int i = 0; i < int'(NSRC); i++) begin
            clr[i] = (w1c && bus_wdata[i]) || (claim && (win_idx == 5'(i)));
        end
        pend_d = (edge_q & (set | (pend_q & ~clr))) | (~edge_q & src_s);
    end

    always_comb begin
        bus_rdata = '0;
        unique case (reg_sel)
            RegPend:   bus_rdata = 32'(pend_q);
            RegMask:   bus_rdata = 32'(mask_q);
            RegEdge:   bus_rdata = 32'(edge_q);
            RegClaim:  bus_rdata = claim ? 32'(win_id) : 32'd0;
            RegStatus: bus_rdata = {26'b0, state_q == StService, isr_id_q};
            default:   bus_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            pend_q <= '0;
            mask_q <= '0;
            edge_q <= '0;
            irq_id <= '0;
            hw_q   <= 1'b0;
        end else begin
            hist_q <= src_s;
            pend_q <= pend_d;
            if (bus_we && (reg_sel == RegMask)) mask_q <= bus_wdata[NSRC-1:0];
            if (bus_we && (reg_sel == RegEdge)) edge_q <= bus_wdata[NSRC-1:0];
            irq_id <= win_valid ? win_id : 5'd0;
            hw_q   <= (|pend_en) && (state_q == StIdle);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            isr_id_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (claim) begin
                        state_q  <= StService;
                        isr_id_q <= win_id;
                    end
                end
                StService: begin
                    if (complete) begin
                        state_q  <= StIdle;
                        isr_id_q <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        hw_int       = '0;
        hw_int[LINE] = hw_q;
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl; register reads are scored against an expected-value queue.
module tb_int_ctrl;

`ifdef INT_CTRL_SYNC_EN
    localparam int Lat = 4;
`else
    localparam int Lat = 2;
`endif

    localparam logic [4:0] APend = 5'h00, AMask = 5'h04, AEdge = 5'h08,
                           AClaim = 5'h0C, AStatus = 5'h10, AHole = 5'h14;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  src = '0;
    logic [4:0]  bus_addr = '0;
    logic        bus_we = 1'b0;
    logic        bus_re = 1'b0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic [5:0]  hw_int;
    logic [4:0]  irq_id;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    int_ctrl #(
        .NSRC(8),
        .LINE(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .src      (src),
        .bus_addr (bus_addr),
        .bus_we   (bus_we),
        .bus_re   (bus_re),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .hw_int   (hw_int),
        .irq_id   (irq_id)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_wr(input logic [4:0] addr, input logic [31:0] data);
        bus_addr  = addr;
        bus_wdata = data;
        bus_we    = 1'b1;
        tick();
        bus_we    = 1'b0;
    endtask

    // Push the expectation, then read and score against the popped entry.
    task automatic rd_expect(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        bus_addr = addr;
        bus_re   = 1'b1;
        #1;
        check_eq(tag_q.pop_front(), bus_rdata, exp_q.pop_front());
        tick();
        bus_re = 1'b0;
    endtask

    task automatic pulse_and_wait(input logic [7:0] bits);
        src = bits;
        tick();
        src = '0;
        repeat (Lat - 1) tick();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_eq("rst_hw", 32'(hw_int), 32'h0);
        check_eq("rst_irq", 32'(irq_id), 32'h0);
        rd_expect("rst_pend", APend, 32'h0);
        rd_expect("rst_mask", AMask, 32'h0);
        rd_expect("rst_edge", AEdge, 32'h0);
        rd_expect("rst_status", AStatus, 32'h0);
        rd_expect("rst_claim", AClaim, 32'h0);
        rd_expect("hole_read", AHole, 32'h0);

        // Single edge source, claim and complete
        bus_wr(AEdge, 32'h01);
        bus_wr(AMask, 32'h01);
        src[0] = 1'b1;
        tick();
        src = '0;
        repeat (Lat - 2) tick();
        check_eq("lat_early_hw", 32'(hw_int), 32'h0);
        tick();
        check_eq("lat_hw", 32'(hw_int), 32'h4);
        check_eq("t2_irq", 32'(irq_id), 32'd1);
        rd_expect("t2_claim", AClaim, 32'd1);
        rd_expect("t2_status", AStatus, 32'h21);
        check_eq("t2_hw_svc", 32'(hw_int), 32'h0);
        rd_expect("t2_pend", APend, 32'h0);
        bus_wr(AClaim, 32'd1);
        rd_expect("t2_status_done", AStatus, 32'h0);

        // Masking the winner drops hw_int the following cycle
        pulse_and_wait(8'h01);
        check_eq("mask_hw_pre", 32'(hw_int), 32'h4);
        bus_wr(AMask, 32'h0);
        tick();
        check_eq("mask_hw_drop", 32'(hw_int), 32'h0);
        bus_wr(APend, 32'h01);
        rd_expect("w1c_clear", APend, 32'h0);
        bus_wr(AMask, 32'hFFFF_FFFF);
        rd_expect("mask_width", AMask, 32'hFF);

        // Fixed priority
        bus_wr(AEdge, 32'hFF);
        pulse_and_wait(8'h28);
        check_eq("prio_irq", 32'(irq_id), 32'd4);
        rd_expect("prio_claim4", AClaim, 32'd4);
        bus_wr(AClaim, 32'd4);
        rd_expect("prio_claim6", AClaim, 32'd6);
        bus_wr(AClaim, 32'd6);
        rd_expect("prio_status", AStatus, 32'h0);

        // Level source
        bus_wr(AEdge, 32'h0);
        bus_wr(AMask, 32'h02);
        src[1] = 1'b1;
        repeat (Lat) tick();
        check_eq("lvl_hw", 32'(hw_int), 32'h4);
        rd_expect("lvl_claim", AClaim, 32'd2);
        rd_expect("lvl_pend_kept", APend, 32'h02);
        bus_wr(APend, 32'h02);
        rd_expect("lvl_w1c_ignored", APend, 32'h02);
        bus_wr(AClaim, 32'd2);
        tick();
        check_eq("lvl_hw_reassert", 32'(hw_int), 32'h4);
        src = '0;
        repeat (Lat - 1) tick();
        rd_expect("lvl_pend_drop", APend, 32'h0);
        check_eq("lvl_hw_drop", 32'(hw_int), 32'h0);

        // Set beats W1C in the same cycle
        bus_wr(AEdge, 32'h01);
        bus_wr(AMask, 32'h01);
        src[0] = 1'b1;
        if (Lat > 2) begin
            tick();
            src = '0;
            repeat (Lat - 3) tick();
        end
        bus_wr(APend, 32'h01);
        src = '0;
        rd_expect("set_wins", APend, 32'h01);

        // Wrong-id complete and no nesting
        rd_expect("c_claim", AClaim, 32'd1);
        bus_wr(AClaim, 32'd3);
        rd_expect("wrong_id_status", AStatus, 32'h21);
        pulse_and_wait(8'h01);
        rd_expect("nest_claim", AClaim, 32'd0);
        rd_expect("svc_pend", APend, 32'h01);

        // Reset in SERVICE
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        rd_expect("rst2_status", AStatus, 32'h0);
        rd_expect("rst2_pend", APend, 32'h0);
        rd_expect("rst2_mask", AMask, 32'h0);
        check_eq("rst2_hw", 32'(hw_int), 32'h0);

        // Quiet sources never assert
        bus_wr(AMask, 32'hFF);
        repeat (6) tick();
        check_eq("quiet_hw", 32'(hw_int), 32'h0);
        rd_expect("quiet_claim", AClaim, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
